// File: rtl/time_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : time_gen_pkg
//  Description : Shared constants and helpers for the alarm-clock timebase.
//                - DEFAULT_CLK_DIV     : clk256 cycles per second tick
//                - DEFAULT_SEC_PER_MIN : second ticks per minute tick
//                - counter_width()     : bit width for a modulo-N counter
//  Revision    : 1.0 - initial release
// ============================================================================
package time_gen_pkg;

    localparam int DEFAULT_CLK_DIV     = 256;
    localparam int DEFAULT_SEC_PER_MIN = 60;

    // Width needed to hold 0..modulus-1; never narrower than one bit.
    function automatic int counter_width(input int modulus);
        return (modulus <= 2) ? 1 : $clog2(modulus);
    endfunction

endpackage : time_gen_pkg
`default_nettype wire

// File: rtl/time_gen_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : time_gen_mod_counter
//  Description : Modulo-MOD up-counter with a terminal flag.
//  Ports       : clk      - clock, rising edge
//                reset    - asynchronous active-low reset
//                enable   - advance the count on this edge
//                count    - current count, 0..MOD-1
//                terminal - high when count==MOD-1 and enable is high
//  Revision    : 1.0 - initial release
// ============================================================================
module time_gen_mod_counter
    import time_gen_pkg::*;
#(
    parameter int MOD   = DEFAULT_CLK_DIV,
    parameter int WIDTH = counter_width(MOD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == c_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

    assign count    = r_count;
    assign terminal = enable && w_at_last;

endmodule : time_gen_mod_counter
`default_nettype wire

// File: rtl/time_gen.sv
`default_nettype none
// ============================================================================
//  Module      : time_gen
//  Description : Timebase generator. Divides clk256 into a one-second tick
//                and a one-minute tick (one per second when fast_mode=1).
//  Ports       : clk256      - 256 Hz system clock, rising edge
//                reset       - asynchronous active-low reset
//                fast_mode   - 1 = minute tick on every second tick
//                one_second  - 1-cycle pulse every CLK_DIV clocks
//                one_minute  - 1-cycle pulse per minute, coincident with
//                              one_second
//                half_second - 50% square wave (only with
//                              TIME_GEN_HALF_SECOND_EN defined)
//  Config      : `define TIME_GEN_HALF_SECOND_EN adds half_second.
//  Revision    : 1.0 - initial release
// ============================================================================
module time_gen
    import time_gen_pkg::*;
#(
    parameter int CLK_DIV     = DEFAULT_CLK_DIV,
    parameter int SEC_PER_MIN = DEFAULT_SEC_PER_MIN
) (
    input  logic clk256,
    input  logic reset,
    input  logic fast_mode,
    output logic one_second,
    output logic one_minute
`ifdef TIME_GEN_HALF_SECOND_EN
    ,
    output logic half_second
`endif
);

    localparam int c_pre_w = counter_width(CLK_DIV);
    localparam int c_sec_w = counter_width(SEC_PER_MIN);

    logic [c_pre_w-1:0] w_pre_count;
    logic               w_pre_terminal;
    logic [c_sec_w-1:0] w_sec_count;
    logic               w_sec_terminal;

    logic r_one_second;
    logic r_one_minute;

    time_gen_mod_counter #(
        .MOD   (CLK_DIV),
        .WIDTH (c_pre_w)
    ) u_prescaler (
        .clk      (clk256),
        .reset    (reset),
        .enable   (1'b1),
        .count    (w_pre_count),
        .terminal (w_pre_terminal)
    );

    time_gen_mod_counter #(
        .MOD   (SEC_PER_MIN),
        .WIDTH (c_sec_w)
    ) u_seconds (
        .clk      (clk256),
        .reset    (reset),
        .enable   (w_pre_terminal),
        .count    (w_sec_count),
        .terminal (w_sec_terminal)
    );

    // Both pulses are registered copies of terminal flags, so they are one
    // cycle wide and one_minute can only rise on a tick edge. fast_mode only
    // matters on tick edges because both of its choices are zero elsewhere.
    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            r_one_second <= 1'b0;
            r_one_minute <= 1'b0;
        end else begin
            r_one_second <= w_pre_terminal;
            r_one_minute <= fast_mode ? w_pre_terminal : w_sec_terminal;
        end
    end

    assign one_second = r_one_second;
    assign one_minute = r_one_minute;

    // The seconds count is only needed through its terminal flag.
    logic w_sec_unused;
    assign w_sec_unused = ^w_sec_count;

`ifdef TIME_GEN_HALF_SECOND_EN
    localparam logic [c_pre_w-1:0] c_half_m1 = c_pre_w'(CLK_DIV / 2 - 1);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(CLK_DIV - 1);

    logic r_half_second;
    logic w_half_next;

    // Compare against the prescaler value this edge will load, so the
    // register is high exactly while the prescaler sits in the upper half.
    assign w_half_next = (w_pre_count >= c_half_m1) && (w_pre_count != c_pre_last);

    always_ff @(posedge clk256 or negedge reset) begin
        if (!reset) begin
            r_half_second <= 1'b0;
        end else begin
            r_half_second <= w_half_next;
        end
    end

    assign half_second = r_half_second;
`else
    logic w_pre_unused;
    assign w_pre_unused = ^w_pre_count;
`endif

endmodule : time_gen
`default_nettype wire

// File: tb/tb_time_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_time_gen
//  Description : Directed self-checking bench for time_gen. Expected pulse
//                values come from the edge count since reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_time_gen;

    localparam int CLK_DIV = 256;
    localparam int SPM     = 60;

    logic clk256    = 1'b0;
    logic reset     = 1'b0;
    logic fast_mode = 1'b0;
    logic one_second;
    logic one_minute;
`ifdef TIME_GEN_HALF_SECOND_EN
    logic half_second;
`endif

    int checks = 0;
    int errors = 0;
    int e      = 0;   // rising edges since reset release

    always #5 clk256 = ~clk256;

    time_gen #(
        .CLK_DIV     (CLK_DIV),
        .SEC_PER_MIN (SPM)
    ) dut (
        .clk256      (clk256),
        .reset       (reset),
        .fast_mode   (fast_mode),
        .one_second  (one_second),
        .one_minute  (one_minute)
`ifdef TIME_GEN_HALF_SECOND_EN
        ,
        .half_second (half_second)
`endif
    );

    task automatic check(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp_v);
        end
    endtask

    // Assert reset between edges, hold it for three edges, release on a
    // falling edge so the next rising edge is edge 1.
    task automatic apply_reset(input logic fm);
        reset     = 1'b0;
        fast_mode = fm;
        #1;
        check("reset_sec", one_second, 1'b0);
        check("reset_min", one_minute, 1'b0);
        repeat (3) begin
            @(posedge clk256);
            #1;
            check("hold_sec", one_second, 1'b0);
            check("hold_min", one_minute, 1'b0);
        end
        @(negedge clk256);
        reset = 1'b1;
        e     = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            logic fm;
            logic xs;
            logic xm;
            fm = fast_mode;
            @(posedge clk256);
            #1;
            e++;
            xs = (e % CLK_DIV == 0);
            xm = xs && (fm || ((e / CLK_DIV) % SPM == 0));
            check("one_second", one_second, xs);
            check("one_minute", one_minute, xm);
`ifdef TIME_GEN_HALF_SECOND_EN
            check("half_second", half_second, logic'((e % CLK_DIV) >= CLK_DIV / 2));
`endif
        end
    endtask

    initial begin
        // Reset, second period and normal-mode minutes (edges 256, 15360, 30720)
        apply_reset(1'b0);
        run(30721);

        // Fast mode from reset, then drop to normal mode after edge 1000
        apply_reset(1'b1);
        run(1000);
        fast_mode = 1'b0;
        run(14361);

        // Reset mid-count at prescaler=100
        apply_reset(1'b0);
        run(100);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_sec", one_second, 1'b0);
        check("midrst_min", one_minute, 1'b0);
`ifdef TIME_GEN_HALF_SECOND_EN
        check("midrst_half", half_second, 1'b0);
`endif
        @(negedge clk256);
        reset = 1'b1;
        e     = 0;
        run(256);

        // Reset while the one_second pulse is high: the pulse must vanish
        // without waiting for a clock edge.
        reset = 1'b0;
        #1;
        check("drop_sec", one_second, 1'b0);
        check("drop_min", one_minute, 1'b0);
        @(negedge clk256);
        reset = 1'b1;
        e     = 0;
        run(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_time_gen
`default_nettype wire
